// File: rtl/obi_manager_if.sv
// rtl/obi_manager_if.sv - command/response and OBI A/R-channel bundle for obi_manager
interface obi_manager_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic [ADDR_WIDTH-1:0]   cmd_addr_i;
  logic                    cmd_we_i;
  logic [DATA_WIDTH/8-1:0] cmd_be_i;
  logic [DATA_WIDTH-1:0]   cmd_wdata_i;

  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DATA_WIDTH-1:0]   rsp_rdata_o;
  logic                    rsp_err_o;

  logic                    obi_req_o;
  logic                    obi_gnt_i;
  logic [ADDR_WIDTH-1:0]   obi_addr_o;
  logic                    obi_we_o;
  logic [DATA_WIDTH/8-1:0] obi_be_o;
  logic [DATA_WIDTH-1:0]   obi_wdata_o;

  logic                    obi_rvalid_i;
  logic                    obi_rready_o;
  logic [DATA_WIDTH-1:0]   obi_rdata_i;
  logic                    obi_err_i;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_be_i, cmd_wdata_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  rsp_ready_i,
    output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
    input  obi_gnt_i,
    input  obi_rvalid_i, obi_rdata_i, obi_err_i,
    output obi_rready_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_be_i, cmd_wdata_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output rsp_ready_i,
    input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
    output obi_gnt_i,
    output obi_rvalid_i, obi_rdata_i, obi_err_i,
    input  obi_rready_o
  );
endinterface

// File: rtl/obi_manager.sv
// rtl/obi_manager.sv - single-outstanding OBI manager; optional response watchdog under OBI_MGR_TIMEOUT_EN
module obi_manager #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic          clk_i,
  input logic          reset_ni,
  obi_manager_if.master bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  if (!(ADDR_WIDTH == 32 || ADDR_WIDTH == 64)) begin : g_bad_addr_width
    $error("obi_manager: ADDR_WIDTH must be 32 or 64");
  end
  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
    $error("obi_manager: DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("obi_manager: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
`ifdef OBI_MGR_TIMEOUT_EN
    RESP  = 2'd2,
    DRAIN = 2'd3
`else
    RESP  = 2'd2
`endif
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic cmd_ready;
  logic cmd_fire;
  logic obi_req;
  logic obi_rready;
  logic rsp_capture;

`ifdef OBI_MGR_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  logic        timeout_hit;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    cmd_fire    = 1'b0;
    obi_req     = 1'b0;
    obi_rready  = 1'b0;
    rsp_capture = 1'b0;
`ifdef OBI_MGR_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A pending response may retire in the same cycle a new command is taken.
        cmd_ready = !rsp_valid_q || bus.rsp_ready_i;
        cmd_fire  = bus.cmd_valid_i && cmd_ready;
        if (cmd_fire) state_d = REQ;
      end
      REQ: begin
        obi_req = 1'b1;
        if (bus.obi_gnt_i) state_d = RESP;
      end
      RESP: begin
        obi_rready = 1'b1;
        if (bus.obi_rvalid_i) begin
          rsp_capture = 1'b1;
          state_d     = IDLE;
        end
`ifdef OBI_MGR_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = DRAIN;
        end
`endif
      end
`ifdef OBI_MGR_TIMEOUT_EN
      DRAIN: begin
        // The subordinate still owes one beat; swallow it before accepting new work.
        obi_rready = 1'b1;
        if (bus.obi_rvalid_i) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (cmd_fire) begin
      addr_q  <= bus.cmd_addr_i;
      we_q    <= bus.cmd_we_i;
      be_q    <= bus.cmd_be_i;
      wdata_q <= bus.cmd_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (rsp_capture) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= bus.obi_rdata_i;
      rsp_err_q   <= bus.obi_err_i;
    end
`ifdef OBI_MGR_TIMEOUT_EN
    else if (timeout_hit) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b1;
    end
`endif
    else if (rsp_valid_q && bus.rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

`ifdef OBI_MGR_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                                    cnt_q <= '0;
    else if (state_q == RESP && !bus.obi_rvalid_i)    cnt_q <= 16'(cnt_q + 16'd1);
    else                                              cnt_q <= '0;
  end
`endif

  assign bus.cmd_ready_o  = cmd_ready;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_rdata_o  = rsp_rdata_q;
  assign bus.rsp_err_o    = rsp_err_q;

  // A-channel payload is zeroed whenever no request is outstanding.
  assign bus.obi_req_o    = obi_req;
  assign bus.obi_addr_o   = obi_req ? addr_q  : '0;
  assign bus.obi_we_o     = obi_req ? we_q    : 1'b0;
  assign bus.obi_be_o     = obi_req ? be_q    : '0;
  assign bus.obi_wdata_o  = obi_req ? wdata_q : '0;
  assign bus.obi_rready_o = obi_rready;
endmodule

// File: tb/tb_obi_manager.sv
// tb/tb_obi_manager.sv - directed self-checking bench for obi_manager
module tb_obi_manager;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef OBI_MGR_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   hs_count = 0;
  int   hs_base  = 0;

  obi_manager_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  obi_manager #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.obi_req_o && bus.obi_gnt_i) hs_count <= hs_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = addr;
    bus.cmd_we_i    = we;
    bus.cmd_be_i    = be;
    bus.cmd_wdata_i = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_addr_i   = '0;
    bus.cmd_we_i     = 1'b0;
    bus.cmd_be_i     = '0;
    bus.cmd_wdata_i  = '0;
    bus.rsp_ready_i  = 1'b0;
    bus.obi_gnt_i    = 1'b0;
    bus.obi_rvalid_i = 1'b0;
    bus.obi_rdata_i  = '0;
    bus.obi_err_i    = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_obi_req",   64'(bus.obi_req_o), 64'd0);
    check("rst_rready",    64'(bus.obi_rready_o), 64'd0);
    check("rst_rdata",     64'(bus.rsp_rdata_o), 64'd0);
    check("rst_err",       64'(bus.rsp_err_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Stray rvalid in IDLE is ignored
    bus.obi_rvalid_i = 1'b1;
    bus.obi_rdata_i  = 32'h55;
    #1;
    check("idle_rready", 64'(bus.obi_rready_o), 64'd0);
    tick();
    bus.obi_rvalid_i = 1'b0;
    check("idle_rvalid_ignored", 64'(bus.rsp_valid_o), 64'd0);

    // Minimum-latency read
    drive_cmd(32'h10, 1'b0, 4'hF, 32'h0);
    #1;
    check("rd_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    check("rd_req_before", 64'(bus.obi_req_o), 64'd0);
    tick();
    bus.cmd_valid_i = 1'b0;
    check("rd_req_c1",   64'(bus.obi_req_o), 64'd1);
    check("rd_addr_c1",  64'(bus.obi_addr_o), 64'h10);
    check("rd_we_c1",    64'(bus.obi_we_o), 64'd0);
    check("rd_rready_c1", 64'(bus.obi_rready_o), 64'd0);
    bus.obi_gnt_i = 1'b1;
    tick();
    bus.obi_gnt_i = 1'b0;
    check("rd_req_c2",    64'(bus.obi_req_o), 64'd0);
    check("rd_addr_c2",   64'(bus.obi_addr_o), 64'd0);
    check("rd_rready_c2", 64'(bus.obi_rready_o), 64'd1);
    check("rd_rsp_c2",    64'(bus.rsp_valid_o), 64'd0);
    bus.obi_rvalid_i = 1'b1;
    bus.obi_rdata_i  = 32'hDEADBEEF;
    bus.obi_err_i    = 1'b0;
    tick();
    bus.obi_rvalid_i = 1'b0;
    bus.obi_rdata_i  = '0;
    check("rd_rsp_valid_c3", 64'(bus.rsp_valid_o), 64'd1);
    check("rd_rsp_rdata_c3", 64'(bus.rsp_rdata_o), 64'hDEADBEEF);
    check("rd_rsp_err_c3",   64'(bus.rsp_err_o), 64'd0);
    check("rd_cmd_ready_blocked", 64'(bus.cmd_ready_o), 64'd0);
    bus.rsp_ready_i = 1'b1;
    #1;
    check("rd_cmd_ready_on_accept", 64'(bus.cmd_ready_o), 64'd1);
    tick();
    bus.rsp_ready_i = 1'b0;
    check("rd_rsp_cleared", 64'(bus.rsp_valid_o), 64'd0);

    // Write with grant delayed four cycles
    hs_base = hs_count;
    drive_cmd(32'h20, 1'b1, 4'hF, 32'hA5A5A5A5);
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_wdata_i = '0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wr_req_%0d", i),   64'(bus.obi_req_o), 64'd1);
      check($sformatf("wr_addr_%0d", i),  64'(bus.obi_addr_o), 64'h20);
      check($sformatf("wr_we_%0d", i),    64'(bus.obi_we_o), 64'd1);
      check($sformatf("wr_be_%0d", i),    64'(bus.obi_be_o), 64'hF);
      check($sformatf("wr_wdata_%0d", i), 64'(bus.obi_wdata_o), 64'hA5A5A5A5);
      if (i == 4) bus.obi_gnt_i = 1'b1;
      tick();
    end
    bus.obi_gnt_i = 1'b0;
    check("wr_req_dropped", 64'(bus.obi_req_o), 64'd0);
    check("wr_wdata_zero",  64'(bus.obi_wdata_o), 64'd0);
    check("wr_handshakes",  64'(hs_count - hs_base), 64'd1);

    // Error response held under backpressure while a second command waits
    bus.obi_rvalid_i = 1'b1;
    bus.obi_err_i    = 1'b1;
    tick();
    bus.obi_rvalid_i = 1'b0;
    bus.obi_err_i    = 1'b0;
    drive_cmd(32'h30, 1'b0, 4'h3, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_rsp_valid_%0d", i), 64'(bus.rsp_valid_o), 64'd1);
      check($sformatf("bp_rsp_err_%0d", i),   64'(bus.rsp_err_o), 64'd1);
      check($sformatf("bp_cmd_ready_%0d", i), 64'(bus.cmd_ready_o), 64'd0);
      check($sformatf("bp_obi_req_%0d", i),   64'(bus.obi_req_o), 64'd0);
      tick();
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    check("bp_cmd_ready_release", 64'(bus.cmd_ready_o), 64'd1);
    tick();
    bus.rsp_ready_i = 1'b0;
    bus.cmd_valid_i = 1'b0;
    check("bp_rsp_cleared", 64'(bus.rsp_valid_o), 64'd0);
    check("bp_req2",        64'(bus.obi_req_o), 64'd1);
    check("bp_addr2",       64'(bus.obi_addr_o), 64'h30);
    check("bp_be2",         64'(bus.obi_be_o), 64'h3);
    bus.obi_gnt_i = 1'b1;
    tick();
    bus.obi_gnt_i    = 1'b0;
    bus.obi_rvalid_i = 1'b1;
    bus.obi_rdata_i  = 32'h12345678;
    tick();
    bus.obi_rvalid_i = 1'b0;
    bus.obi_rdata_i  = '0;
    check("bp_rsp2_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("bp_rsp2_rdata", 64'(bus.rsp_rdata_o), 64'h12345678);
    check("bp_rsp2_err",   64'(bus.rsp_err_o), 64'd0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;

    // Reset in RESP discards the transaction
    drive_cmd(32'h40, 1'b0, 4'hF, 32'h0);
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.obi_gnt_i   = 1'b1;
    tick();
    bus.obi_gnt_i = 1'b0;
    check("rr_in_resp", 64'(bus.obi_rready_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rr_rready",    64'(bus.obi_rready_o), 64'd0);
    check("rr_req",       64'(bus.obi_req_o), 64'd0);
    check("rr_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    check("rr_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rr_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
    check("rr_rsp_err",   64'(bus.rsp_err_o), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.obi_rvalid_i = 1'b1;
    bus.obi_rdata_i  = 32'hBAD0BAD0;
    tick();
    bus.obi_rvalid_i = 1'b0;
    bus.obi_rdata_i  = '0;
    tick();
    check("rr_no_rsp",     64'(bus.rsp_valid_o), 64'd0);
    check("rr_no_rdata",   64'(bus.rsp_rdata_o), 64'd0);
    check("rr_idle_ready", 64'(bus.cmd_ready_o), 64'd1);

`ifdef OBI_MGR_TIMEOUT_EN
    // Watchdog: no rvalid after grant
    drive_cmd(32'h50, 1'b0, 4'hF, 32'h0);
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.obi_gnt_i   = 1'b1;
    tick();
    bus.obi_gnt_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("to_wait_rsp_%0d", i),    64'(bus.rsp_valid_o), 64'd0);
      check($sformatf("to_wait_rready_%0d", i), 64'(bus.obi_rready_o), 64'd1);
      tick();
    end
    check("to_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("to_rsp_err",   64'(bus.rsp_err_o), 64'd1);
    check("to_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
    check("to_drain_rready", 64'(bus.obi_rready_o), 64'd1);
    bus.rsp_ready_i = 1'b1;
    bus.cmd_valid_i = 1'b1;
    #1;
    check("to_drain_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
    tick();
    bus.rsp_ready_i = 1'b0;
    bus.cmd_valid_i = 1'b0;
    check("to_rsp_cleared", 64'(bus.rsp_valid_o), 64'd0);
    check("to_still_drain", 64'(bus.obi_rready_o), 64'd1);
    bus.obi_rvalid_i = 1'b1;
    bus.obi_rdata_i  = 32'h0000BAD0;
    tick();
    bus.obi_rvalid_i = 1'b0;
    bus.obi_rdata_i  = '0;
    check("to_late_dropped", 64'(bus.rsp_valid_o), 64'd0);
    check("to_back_idle",    64'(bus.cmd_ready_o), 64'd1);
    check("to_idle_rready",  64'(bus.obi_rready_o), 64'd0);
    drive_cmd(32'h60, 1'b0, 4'hF, 32'h0);
    tick();
    bus.cmd_valid_i = 1'b0;
    check("to_next_req", 64'(bus.obi_req_o), 64'd1);
    bus.obi_gnt_i = 1'b1;
    tick();
    bus.obi_gnt_i    = 1'b0;
    bus.obi_rvalid_i = 1'b1;
    bus.obi_rdata_i  = 32'h0000600D;
    tick();
    bus.obi_rvalid_i = 1'b0;
    check("to_next_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("to_next_rdata", 64'(bus.rsp_rdata_o), 64'h600D);
    check("to_next_err",   64'(bus.rsp_err_o), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/obi_manager.md
OBI_MANAGER -- requirements
Module: obi_manager

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: OBI address width, 32 or 64.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: OBI data width, 32 or 64.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: response watchdog limit, 1..65535.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_ni, input, 1: asynchronous active-low reset.
REQ-006 SHALL have ports cmd_valid_i, input, 1 and cmd_ready_o, output, 1: command handshake.
REQ-007 SHALL have ports cmd_addr_i, input, ADDR_WIDTH; cmd_we_i, input, 1; cmd_be_i, input, DATA_WIDTH/8; cmd_wdata_i, input, DATA_WIDTH: command payload.
REQ-008 SHALL have ports rsp_valid_o, output, 1 and rsp_ready_i, input, 1: response handshake.
REQ-009 SHALL have ports rsp_rdata_o, output, DATA_WIDTH and rsp_err_o, output, 1: response payload.
REQ-010 SHALL have ports obi_req_o, output, 1 and obi_gnt_i, input, 1: OBI A-channel handshake.
REQ-011 SHALL have ports obi_addr_o, output, ADDR_WIDTH; obi_we_o, output, 1; obi_be_o, output, DATA_WIDTH/8; obi_wdata_o, output, DATA_WIDTH: OBI A-channel payload.
REQ-012 SHALL have ports obi_rvalid_i, input, 1; obi_rready_o, output, 1; obi_rdata_i, input, DATA_WIDTH; obi_err_i, input, 1: OBI R-channel.

Function
REQ-013 SHALL implement states IDLE, REQ, RESP, DRAIN, with at most one outstanding OBI transaction.
REQ-014 SHALL drive cmd_ready_o = (state==IDLE) && (!rsp_valid_o || rsp_ready_i).
REQ-015 On cmd_valid_i && cmd_ready_o, SHALL latch addr/we/be/wdata into registers and go to REQ; obi_req_o rises on the next cycle.
REQ-016 In REQ, SHALL hold obi_req_o=1 and all A-channel outputs stable from the latched registers until obi_gnt_i=1, then go to RESP.
REQ-017 SHALL never deassert obi_req_o before grant; REQ has no timeout.
REQ-018 Outside REQ, SHALL drive obi_req_o=0 and obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o to 0.
REQ-019 In RESP, SHALL drive obi_rready_o=1; on obi_rvalid_i, SHALL capture obi_rdata_i/obi_err_i into the response register, set rsp_valid_o on the next cycle, and go to IDLE.
REQ-020 SHALL keep rsp_valid_o, rsp_rdata_o, rsp_err_o stable until rsp_ready_i=1; rsp_valid_o clears on the next edge unless a new response is captured in the same cycle.
REQ-021 SHALL ignore obi_rvalid_i in IDLE and REQ; in those states obi_rready_o=0.
REQ-022 Minimum command-to-response latency: handshake at cycle 0, gnt at 1, rvalid at 2, rsp_valid_o at 3.
REQ-023 A command accepted in the same cycle as a response is consumed SHALL be handled normally.

Reset
REQ-024 While reset_ni=0, SHALL force state=IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, obi_req_o=0, obi_rready_o=0, timeout counter=0; cmd_ready_o SHALL read 1.
REQ-025 A reset mid-transaction SHALL discard the transaction without emitting a response.

Configuration
REQ-026 With OBI_MGR_TIMEOUT_EN defined, SHALL count RESP cycles without obi_rvalid_i; when the count reaches TIMEOUT_CYCLES, SHALL emit a response with rsp_err_o=1 and rsp_rdata_o=0, then go to DRAIN.
REQ-027 In DRAIN, SHALL hold obi_rready_o=1 and cmd_ready_o=0, discard the next obi_rvalid_i beat, then go to IDLE.
REQ-028 Without OBI_MGR_TIMEOUT_EN, SHALL omit the counter and DRAIN, and SHALL wait in RESP indefinitely.

Verification
REQ-029 Read addr=0x10 at cycle 0; gnt at 1; rvalid at 2 with rdata=0xDEADBEEF, err=0 -> rsp_valid_o at 3, rdata=0xDEADBEEF, err=0.
REQ-030 Write addr=0x20, wdata=0xA5A5A5A5, be=0xF; gnt delayed 4 cycles -> obi_req_o and payload stable for 5 cycles, with exactly one A-channel handshake.
REQ-031 Response held while rsp_ready_i=0 for 3 cycles, then a second command offered -> cmd_ready_o=0 until rsp_ready_i=1, then accepted in that same cycle.
REQ-032 Reset asserted in RESP -> all outputs reach their reset values immediately, and no response is emitted after release.
REQ-033 With OBI_MGR_TIMEOUT_EN and TIMEOUT_CYCLES=8, no rvalid after gnt -> err response 8 cycles after entering RESP; a late rvalid is dropped, then the next command completes normally.
